// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

   localparam logic [31:0] NOP              = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        fault;
   } fetch_entry_t;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } mode_t;

   // Word-aligned and inside the ROM; the limit is widened so IMEM_WORDS*4 cannot overflow.
   function automatic logic pc_is_legal(input logic [31:0] pc, input int unsigned words);
      logic [32:0] limit;
      limit = 33'(words) << 2;
      return (pc[1:0] == 2'b00) && ({1'b0, pc} < limit);
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO between fetch and decode; head and tail kept as a shift pair
// so the head is always a register and reads zero when the queue is empty.
module fetch_queue
   import fetch_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         push,
   input  fetch_entry_t push_entry,
   input  logic         pop,
   output logic         full,
   output logic         empty,
   output fetch_entry_t head
);

   fetch_entry_t head_q, head_d;
   fetch_entry_t tail_q, tail_d;
   logic [1:0]   count_q, count_d;
   logic         pop_eff;

   assign empty   = (count_q == 2'd0);
   assign full    = (count_q == 2'd2);
   assign pop_eff = pop && !empty;
   assign head    = head_q;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = 2'd0;
      end else begin
         case ({push, pop_eff})
            2'b10: begin
               if (count_q == 2'd0) head_d = push_entry;
               else                 tail_d = push_entry;
               count_d = count_q + 2'd1;
            end
            2'b01: begin
               head_d  = tail_q;
               tail_d  = '0;
               count_d = count_q - 2'd1;
            end
            2'b11: begin
               if (count_q == 2'd1) begin
                  head_d = push_entry;
               end else begin
                  head_d = tail_q;
                  tail_d = push_entry;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= 2'd0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: owns the PC, reads the combinational ROM, queues words for
// decode, handles redirects and halts on an illegal fetch address.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
   parameter int unsigned IMEM_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        inst_fault
);

   logic [31:0]  fetch_pc_q, fetch_pc_d;
   mode_t        mode_q, mode_d;
   logic         q_full, q_empty;
   logic         deq, enq;
   fetch_entry_t push_entry, head_entry;

   assign imem_addr  = fetch_pc_q;
   assign deq        = !q_empty && inst_ready;
   assign inst_valid = !q_empty;
   assign inst       = head_entry.inst;
   assign inst_pc    = head_entry.pc;
   assign inst_fault = head_entry.fault;

   // Redirect wins over everything; otherwise fetch only when the slot frees up this edge.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      mode_d     = mode_q;
      enq        = 1'b0;
      push_entry = '0;
      if (redirect_valid) begin
         fetch_pc_d = redirect_pc;
         mode_d     = RUN;
      end else if (mode_q == RUN && (!q_full || deq)) begin
         enq = 1'b1;
         if (pc_is_legal(fetch_pc_q, IMEM_WORDS)) begin
            push_entry = '{pc: fetch_pc_q, inst: imem_rdata, fault: 1'b0};
            fetch_pc_d = fetch_pc_q + 32'd4;
         end else begin
            push_entry = '{pc: fetch_pc_q, inst: NOP, fault: 1'b1};
            mode_d     = HALT;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q <= RESET_PC;
         mode_q     <= RUN;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         mode_q     <= mode_d;
      end
   end

   fetch_queue u_queue (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (redirect_valid),
      .push       (enq),
      .push_entry (push_entry),
      .pop        (deq),
      .full       (q_full),
      .empty      (q_empty),
      .head       (head_entry)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_fault;

   int tests = 0;
   int fails = 0;

   logic [31:0] rom [0:1023];
   logic [31:0] lit [0:3];

   typedef struct {
      logic [31:0] pc;
      logic [31:0] word;
      logic        fault;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] m_pc = 32'h0;
   bit          m_halted = 1'b0;

   always #5 clk = ~clk;

   assign imem_rdata = (imem_addr < 32'd4096) ? rom[imem_addr[11:2]] : 32'hBAD0_BAD0;

   fetch_unit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .inst_fault     (inst_fault)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a queue of fetched words plus a PC and halt flag.
   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            mq.delete();
            m_pc     = 32'h0;
            m_halted = 1'b0;
         end else if (redirect_valid) begin
            mq.delete();
            m_pc     = redirect_pc;
            m_halted = 1'b0;
         end else begin
            if (mq.size() > 0 && inst_ready) void'(mq.pop_front());
            if (!m_halted && mq.size() < 2) begin
               if (m_pc[1:0] == 2'b00 && m_pc < 32'd4096) begin
                  mq.push_back('{pc: m_pc, word: rom[m_pc >> 2], fault: 1'b0});
                  m_pc = m_pc + 32'd4;
               end else begin
                  mq.push_back('{pc: m_pc, word: 32'h0000_0013, fault: 1'b1});
                  m_halted = 1'b1;
               end
            end
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         check("model_valid", {31'b0, inst_valid}, {31'b0, mq.size() > 0});
         check("model_imem_addr", imem_addr, m_pc);
         if (mq.size() > 0) begin
            check("model_inst", inst, mq[0].word);
            check("model_inst_pc", inst_pc, mq[0].pc);
            check("model_fault", {31'b0, inst_fault}, {31'b0, mq[0].fault});
         end else begin
            check("model_inst_empty", inst, 32'h0);
            check("model_pc_empty", inst_pc, 32'h0);
            check("model_fault_empty", {31'b0, inst_fault}, 32'h0);
         end
      end
   end

   task automatic redirect_to(input logic [31:0] target);
      redirect_valid = 1'b1;
      redirect_pc    = target;
      @(negedge clk);
      redirect_valid = 1'b0;
   endtask

   initial begin
      logic [31:0] rpc;
      lit[0] = 32'h0050_0093;
      lit[1] = 32'h00A0_0113;
      lit[2] = 32'h0020_81B3;
      lit[3] = 32'h0030_2023;
      for (int i = 0; i < 1024; i++) rom[i] = $urandom;
      for (int i = 0; i < 4; i++) rom[i] = lit[i];

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_valid", {31'b0, inst_valid}, 32'h0);
      check("rst_imem_addr", imem_addr, 32'h0);
      check("rst_inst", inst, 32'h0);
      rst_n = 1'b1;
      inst_ready = 1'b1;

      // Straight-line fetch, one per cycle
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         $display("[TB] seq k=%0d pc=%h inst=%h", k, inst_pc, inst);
         check("seq_valid", {31'b0, inst_valid}, 32'h1);
         check("seq_pc", inst_pc, 32'(k * 4));
         check("seq_inst", inst, lit[k]);
         check("seq_fault", {31'b0, inst_fault}, 32'h0);
      end

      // Backpressure after reset
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      inst_ready = 1'b0;
      repeat (5) @(negedge clk);
      check("bp_head_pc", inst_pc, 32'h0);
      check("bp_imem_addr", imem_addr, 32'h8);
      inst_ready = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         $display("[TB] drain pc=%h", inst_pc);
         check("bp_drain_pc", inst_pc, 32'(k * 4));
      end

      // Redirect while full
      inst_ready = 1'b0;
      repeat (2) @(negedge clk);
      redirect_to(32'h1C);
      check("redir_flush_valid", {31'b0, inst_valid}, 32'h0);
      inst_ready = 1'b1;
      @(negedge clk);
      $display("[TB] redirect pc=%h inst=%h", inst_pc, inst);
      check("redir_pc", inst_pc, 32'h1C);
      check("redir_inst", inst, rom[7]);

      // Misaligned target faults and halts
      redirect_to(32'h6);
      @(negedge clk);
      $display("[TB] misaligned pc=%h inst=%h fault=%0d", inst_pc, inst, inst_fault);
      check("mis_pc", inst_pc, 32'h6);
      check("mis_inst", inst, 32'h0000_0013);
      check("mis_fault", {31'b0, inst_fault}, 32'h1);
      repeat (4) @(negedge clk);
      check("halt_valid", {31'b0, inst_valid}, 32'h0);
      check("halt_imem_addr", imem_addr, 32'h6);
      redirect_to(32'h0);
      @(negedge clk);
      check("resume_pc", inst_pc, 32'h0);
      check("resume_inst", inst, lit[0]);

      // End of ROM
      redirect_to(32'hFF8);
      @(negedge clk);
      check("end_pc0", inst_pc, 32'hFF8);
      @(negedge clk);
      check("end_pc1", inst_pc, 32'hFFC);
      check("end_inst1", inst, rom[1023]);
      check("end_fault1", {31'b0, inst_fault}, 32'h0);
      @(negedge clk);
      $display("[TB] end-of-rom pc=%h fault=%0d", inst_pc, inst_fault);
      check("end_pc2", inst_pc, 32'h1000);
      check("end_fault2", {31'b0, inst_fault}, 32'h1);
      check("end_imem_addr", imem_addr, 32'h1000);
      repeat (2) @(negedge clk);
      check("end_halt_valid", {31'b0, inst_valid}, 32'h0);
      check("end_halt_addr", imem_addr, 32'h1000);

      // Asynchronous reset mid-cycle with a full queue
      redirect_to(32'h40);
      inst_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("arst_pre_valid", {31'b0, inst_valid}, 32'h1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      $display("[TB] async reset valid=%0d addr=%h", inst_valid, imem_addr);
      check("arst_valid", {31'b0, inst_valid}, 32'h0);
      check("arst_inst", inst, 32'h0);
      check("arst_pc", inst_pc, 32'h0);
      check("arst_fault", {31'b0, inst_fault}, 32'h0);
      check("arst_imem_addr", imem_addr, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      inst_ready = 1'b1;
      @(negedge clk);
      check("arst_restart_pc", inst_pc, 32'h0);
      check("arst_restart_inst", inst, lit[0]);

      // Randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk);
         #1;
         inst_ready     = ($urandom_range(0, 3) != 0);
         redirect_valid = ($urandom_range(0, 19) == 0);
         case ($urandom_range(0, 3))
            0:       rpc = 32'($urandom_range(0, 1023)) << 2;
            1:       rpc = 32'h1000 - (32'($urandom_range(1, 6)) << 2);
            2:       rpc = (32'($urandom_range(0, 1023)) << 2) | 32'($urandom_range(1, 3));
            default: rpc = $urandom;
         endcase
         redirect_pc = rpc;
         if ($urandom_range(0, 499) == 0) begin
            rst_n = 1'b0;
            #2 rst_n = 1'b1;
         end
         if (c % 500 == 0) $display("[TB] random cycle %0d pc=%h valid=%0d", c, inst_pc, inst_valid);
      end
      redirect_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
